cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among the execution-result producers (ALU, LSB, branch unit) of the out-of-order RISC-V core.
- Each producer hands over a completed result as a (ROB id, value) pair. The arbiter buffers it and broadcasts one result per cycle to the ROB, the reservation stations and the LSB.
- Fairness is round-robin.
- Pending results are dropped on a mispredict rollback from the ROB.

Parameters:
- N_SRC, 3, number of result producers (index 0 = ALU, 1 = LSB, 2 = BRU).
- ROB_ID_W, 4, width of a ROB tag.
- DATA_W, 32, width of a result value.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- rdy  in  1  global run enable; low = pause.
- flush  in  1  ROB rollback; discard all pending results.
- src_valid  in  N_SRC  producer i offers a result.
- src_ready  out  N_SRC  arbiter accepts producer i's result this cycle.
- src_rob_id  in  N_SRC*ROB_ID_W  packed tags; slice i belongs to producer i.
- src_value  in  N_SRC*DATA_W  packed values; slice i belongs to producer i.
- cdb_valid  out  1  broadcast valid.
- cdb_rob_id  out  ROB_ID_W  broadcast tag.
- cdb_value  out  DATA_W  broadcast value.
- cdb_src  out  $clog2(N_SRC)  index of the producer being broadcast.

Interface (already decided): reset is rst, synchronous, active-high; clock is clk.

Behaviour:
- Priority at each clk edge: rst, then rdy low, then flush, then normal operation.

State:
- One holding register per source: hold_v[i], hold_id[i], hold_val[i].
- Round-robin pointer rr_ptr.
- Registered CDB outputs.

Reset:
- hold_v = 0, rr_ptr = 0.
- cdb_valid = 0, cdb_rob_id = 0, cdb_value = 0, cdb_src = 0.
- src_ready = 0 while rst is high.

Accept rule:
- src_ready[i] = rdy & ~flush & ~rst & (~hold_v[i] | grant[i]).
- Transfer when src_valid[i] & src_ready[i]; the holding register loads at that edge.
- When the entry is granted and refilled in the same edge, the new result replaces the granted one, giving full throughput per source.

Arbitration:
- Combinational search over hold_v, starting at rr_ptr and wrapping modulo N_SRC.
- The first valid entry gets grant; grant is one-hot or zero.

Per edge with a grant:
- cdb_valid <= 1.
- cdb_rob_id / cdb_value / cdb_src <= the granted entry.
- hold_v[winner] <= 0, unless it is refilled at the same edge.
- rr_ptr <= winner+1, with wrap from N_SRC-1 to 0.

Per edge without a grant:
- cdb_valid <= 0; cdb data regs hold their values.
- rr_ptr unchanged.

Latency and throughput:
- A result accepted at edge t appears on the CDB at the earliest after edge t+1.
- The CDB is never valid in two consecutive cycles for the same source unless that source was refilled in between.
- Sustained throughput is 1 result per cycle overall.

Pause (rdy=0):
- All registers are frozen; no acceptance.
- cdb_* outputs hold their values, including cdb_valid; consumers are paused identically.

Flush (rdy=1):
- At the edge: hold_v <= 0 and cdb_valid <= 0.
- rr_ptr is preserved.
- src_ready is 0 during the flush cycle, so nothing is accepted.
- A flush raised while rdy=0 has no effect; the ROB holds flush until rdy=1.

Boundaries:
- All sources full: each is served within N_SRC cycles (starvation-free).
- Single requester: served every cycle it has data.
- Out-of-range rr_ptr values are unreachable.

Optional Feature:
- Macro: CDB_ARB_CONTENTION_CNT_EN.
- Defined: adds output port contention_cnt [31:0]. It increments by 1 on each non-paused, non-flush edge where at least one valid holding entry is not granted.
  - Cleared by rst.
  - Saturates at 32'hFFFFFFFF.
  - Frozen while rdy=0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: after rst, cdb_valid=0 and src_ready=3'b111 once rdy=1 with hold empty; no CDB activity for 10 cycles.
- Single source: ALU offers id 4'h5, value 32'hDEAD_BEEF at edge t -> cdb_valid=1 with rob_id 5, value DEADBEEF, cdb_src=0 after edge t+1; cdb_valid=0 the following cycle.
- Round-robin: all three sources hold results with rr_ptr=0 (ids 1, 2, 3) -> CDB broadcasts ids 1, 2, 3 on three consecutive cycles; with rr_ptr=1, order is 2, 3, 1.
- Back-to-back refill: LSB streams ids 7, 8, 9 on consecutive cycles while the others are idle -> CDB shows 7, 8, 9 on consecutive cycles and src_ready[1] stays 1.
- Pause: hold rdy=0 for 3 cycles while cdb_valid=1 with id 6 and the ALU offers id 2 -> CDB stays at id 6 and src_ready=0; after rdy=1, id 2 follows.
- Flush: with two held results and cdb_valid=1, assert flush for one cycle -> next cycle cdb_valid=0, hold empty, src_ready=0 during the flush cycle. With CDB_ARB_CONTENTION_CNT_EN, the counter does not increment on the flush edge.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter with one holding register per source; CDB_ARB_CONTENTION_CNT_EN adds contention_cnt
module cdb_arbiter #(
  parameter int N_SRC    = 3,
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  input  logic [N_SRC*ROB_ID_W-1:0]  src_rob_id,
  input  logic [N_SRC*DATA_W-1:0]    src_value,
  output logic                       cdb_valid,
  output logic [ROB_ID_W-1:0]        cdb_rob_id,
  output logic [DATA_W-1:0]          cdb_value,
  output logic [$clog2(N_SRC)-1:0]   cdb_src
`ifdef CDB_ARB_CONTENTION_CNT_EN
  ,
  output logic [31:0]                contention_cnt
`endif
);
  localparam int SW = $clog2(N_SRC);
  logic [N_SRC-1:0]    hold_v, grant, take;
  logic [ROB_ID_W-1:0] hold_id [N_SRC];
  logic [DATA_W-1:0]   hold_val [N_SRC];
  logic [SW-1:0]       rr_ptr, win, idx;
  logic [SW:0]         sum;
  logic                any;
  always_comb begin
    grant = '0;
    win = '0;
    any = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sum = {1'b0, rr_ptr} + (SW+1)'(k);
      idx = sum >= (SW+1)'(N_SRC) ? SW'(sum - (SW+1)'(N_SRC)) : SW'(sum);
      if (!any && hold_v[idx]) begin
        any = 1'b1;
        grant[idx] = 1'b1;
        win = idx;
      end
    end
  end
  // a granted entry frees its slot at the same edge, so it may be refilled immediately
  assign src_ready = {N_SRC{rdy & ~flush & ~rst}} & (~hold_v | grant);
  assign take = src_valid & src_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v <= '0;
      rr_ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value <= '0;
      cdb_src <= '0;
    end else if (rdy) begin
      if (flush) begin
        hold_v <= '0;
        cdb_valid <= 1'b0;
      end else begin
        cdb_valid <= any;
        if (any) begin
          cdb_rob_id <= hold_id[win];
          cdb_value <= hold_val[win];
          cdb_src <= win;
          rr_ptr <= win == SW'(N_SRC-1) ? '0 : win + 1'b1;
        end
        hold_v <= take | (hold_v & ~grant);
        for (int i = 0; i < N_SRC; i++)
          if (take[i]) begin
            hold_id[i] <= src_rob_id[i*ROB_ID_W +: ROB_ID_W];
            hold_val[i] <= src_value[i*DATA_W +: DATA_W];
          end
      end
    end
  end
`ifdef CDB_ARB_CONTENTION_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) contention_cnt <= '0;
    else if (rdy && !flush && |(hold_v & ~grant) && !(&contention_cnt)) contention_cnt <= contention_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus randomized traffic against a behavioural model of cdb_arbiter
module tb_cdb_arbiter;
  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic [2:0]  src_valid = '0;
  logic [2:0]  src_ready;
  logic [11:0] src_rob_id = '0;
  logic [95:0] src_value = '0;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;
`ifdef CDB_ARB_CONTENTION_CNT_EN
  logic [31:0] contention_cnt;
`endif
  int checks = 0, failures = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_rob_id(src_rob_id), .src_value(src_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_value(cdb_value), .cdb_src(cdb_src)
`ifdef CDB_ARB_CONTENTION_CNT_EN
    , .contention_cnt(contention_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic r, f;
    logic [2:0] v;
    logic [3:0] i0, i1, i2;
    logic [2:0] er;
    logic ecv;
    logic [3:0] eid;
    logic [1:0] es;
  } vec_t;
  vec_t tv[$];

  // model: each source holds at most one pending result; a pointer says who is looked at first
  bit          m_hv [3];
  logic [3:0]  m_id [3];
  logic [31:0] m_val [3];
  int          m_ptr;
  logic        m_cv;
  logic [3:0]  m_cid;
  logic [31:0] m_cval;
  logic [1:0]  m_csrc;
  longint      m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] vf(input int i, input logic [3:0] id);
    return 32'hDEAD_BEEF + 32'(i * 16) + 32'(id) - 32'd5;
  endfunction

  function automatic vec_t mk(input logic r, f, input logic [2:0] v, input logic [3:0] i0, i1, i2,
                              input logic [2:0] er, input logic ecv, input logic [3:0] eid, input logic [1:0] es);
    mk = '{r, f, v, i0, i1, i2, er, ecv, eid, es};
  endfunction

  function automatic int m_grant();
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (m_ptr + k) % 3;
      if (m_hv[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_hv[i] = 0;
    m_ptr = 0; m_cv = 0; m_cid = 0; m_cval = 0; m_csrc = 0; m_cnt = 0;
  endtask

  task automatic cycle(input logic r, f, input logic [2:0] v, input logic [11:0] ids,
                       input logic [95:0] vals, output logic [2:0] rd);
    int g, pend;
    logic [2:0] er;
    rdy = r; flush = f; src_valid = v; src_rob_id = ids; src_value = vals;
    #1;
    rd = src_ready;
    g = m_grant();
    pend = 0;
    for (int i = 0; i < 3; i++) begin
      er[i] = r && !f && (!m_hv[i] || g == i);
      pend += int'(m_hv[i]);
    end
    chk("model_ready", 32'(rd), 32'(er));
    @(posedge clk);
    #1;
    if (r && f) begin
      for (int i = 0; i < 3; i++) m_hv[i] = 0;
      m_cv = 0;
    end else if (r) begin
      if (pend > (g >= 0 ? 1 : 0) && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_cv = g >= 0;
      if (g >= 0) begin
        m_cid = m_id[g]; m_cval = m_val[g]; m_csrc = 2'(g);
        m_ptr = (g + 1) % 3;
        m_hv[g] = 0;
      end
      for (int i = 0; i < 3; i++)
        if (v[i] && er[i]) begin
          m_hv[i] = 1; m_id[i] = ids[i*4 +: 4]; m_val[i] = vals[i*32 +: 32];
        end
    end
    chk("model_cdb_valid", 32'(cdb_valid), 32'(m_cv));
    chk("model_cdb_rob_id", 32'(cdb_rob_id), 32'(m_cid));
    chk("model_cdb_value", cdb_value, m_cval);
    chk("model_cdb_src", 32'(cdb_src), 32'(m_csrc));
`ifdef CDB_ARB_CONTENTION_CNT_EN
    chk("model_contention_cnt", contention_cnt, 32'(m_cnt));
`endif
  endtask

  initial begin
    logic [2:0] rd;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(src_ready), 32'h0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'h0);
    chk("rst_cdb_rob_id", 32'(cdb_rob_id), 32'h0);
    chk("rst_cdb_value", cdb_value, 32'h0);
    chk("rst_cdb_src", 32'(cdb_src), 32'h0);
`ifdef CDB_ARB_CONTENTION_CNT_EN
    chk("rst_contention_cnt", contention_cnt, 32'h0);
`endif
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cycle(1, 0, 3'b000, '0, '0, rd);
      chk("idle_ready", 32'(rd), 32'h7);
      chk("idle_cdb_valid", 32'(cdb_valid), 32'h0);
    end

    //           r  f  v       i0     i1     i2     er      cv eid    es
    tv.push_back(mk(1, 0, 3'b001, 4'h5, 4'h0, 4'h0, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 1, 4'h5, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b111, 4'h1, 4'h2, 4'h3, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b010, 1, 4'h2, 2'd1));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b110, 1, 4'h3, 2'd2));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 1, 4'h1, 2'd0));
    tv.push_back(mk(1, 0, 3'b100, 4'h0, 4'h0, 4'hA, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 1, 4'hA, 2'd2));
    tv.push_back(mk(1, 0, 3'b111, 4'h1, 4'h2, 4'h3, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b001, 1, 4'h1, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b011, 1, 4'h2, 2'd1));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 1, 4'h3, 2'd2));
    tv.push_back(mk(1, 0, 3'b010, 4'h0, 4'h7, 4'h0, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b010, 4'h0, 4'h8, 4'h0, 3'b111, 1, 4'h7, 2'd1));
    tv.push_back(mk(1, 0, 3'b010, 4'h0, 4'h9, 4'h0, 3'b111, 1, 4'h8, 2'd1));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 1, 4'h9, 2'd1));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b001, 4'h6, 4'h0, 4'h0, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 1, 4'h6, 2'd0));
    tv.push_back(mk(0, 0, 3'b001, 4'h2, 4'h0, 4'h0, 3'b000, 1, 4'h6, 2'd0));
    tv.push_back(mk(0, 0, 3'b001, 4'h2, 4'h0, 4'h0, 3'b000, 1, 4'h6, 2'd0));
    tv.push_back(mk(0, 0, 3'b001, 4'h2, 4'h0, 4'h0, 3'b000, 1, 4'h6, 2'd0));
    tv.push_back(mk(1, 0, 3'b001, 4'h2, 4'h0, 4'h0, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 1, 4'h2, 2'd0));
    tv.push_back(mk(1, 0, 3'b111, 4'h4, 4'h5, 4'h6, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b010, 1, 4'h5, 2'd1));
    tv.push_back(mk(1, 1, 3'b111, 4'hC, 4'hC, 4'hC, 3'b000, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b111, 4'hA, 4'hB, 4'hC, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b100, 1, 4'hC, 2'd2));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b101, 1, 4'hA, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 1, 4'hB, 2'd1));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b001, 4'hE, 4'h0, 4'h0, 3'b111, 0, 4'h0, 2'd0));
    tv.push_back(mk(0, 1, 3'b000, 4'h0, 4'h0, 4'h0, 3'b000, 0, 4'h0, 2'd0));
    tv.push_back(mk(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 3'b111, 1, 4'hE, 2'd0));

    foreach (tv[n]) begin
      vec_t t;
      t = tv[n];
      cycle(t.r, t.f, t.v, {t.i2, t.i1, t.i0}, {vf(2, t.i2), vf(1, t.i1), vf(0, t.i0)}, rd);
      chk($sformatf("tbl%0d_ready", n), 32'(rd), 32'(t.er));
      chk($sformatf("tbl%0d_cdb_valid", n), 32'(cdb_valid), 32'(t.ecv));
      if (t.ecv) begin
        chk($sformatf("tbl%0d_cdb_rob_id", n), 32'(cdb_rob_id), 32'(t.eid));
        chk($sformatf("tbl%0d_cdb_src", n), 32'(cdb_src), 32'(t.es));
        chk($sformatf("tbl%0d_cdb_value", n), cdb_value, vf(int'(t.es), t.eid));
      end
    end

    for (int n = 0; n < 500; n++)
      cycle($urandom_range(9) != 0, $urandom_range(15) == 0, 3'($urandom), 12'($urandom),
            {$urandom, $urandom, $urandom}, rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
